// File: rtl/relu_pkg.sv
// Shared types and constants for the ReLU pass sequencer.
package relu_pkg;

    localparam int PIX_W  = 16;
    localparam int LANES  = 4;
    localparam int DATA_W = PIX_W * LANES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/relu_dp.sv
// ReLU datapath: per-lane clamp of negative 16-bit pixels, or pass-through.
module relu_dp
    import relu_pkg::*;
(
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Zero any lane whose sign bit is set, only when clamping is enabled
    always_comb begin
        dout = din;
        for (int l = 0; l < LANES; l++) begin
            if (en && din[l*PIX_W + PIX_W - 1]) begin
                dout[l*PIX_W +: PIX_W] = '0;
            end
        end
    end

endmodule

// File: rtl/relu_fifo.sv
// Synchronous result FIFO; push while full is accepted only alongside a pop.
module relu_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at a power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/relu_seq_ctrl.sv
// ReLU pass sequencer: in-order reads, ReLU into a result FIFO, writes out.
//
//  state | meaning
//  IDLE  | waiting for start; config latched on start
//  RUN   | issuing read requests under the FIFO credit limit
//  DRAIN | all reads issued; waiting for the last write to complete
//  FIN   | one-cycle done pulse, then back to IDLE
module relu_seq_ctrl
    import relu_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_relu_en,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [LEN_W+1:0]  clamp_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state;
    state_t             state_nx;

    logic               relu_en_q;
    logic [ADDR_W-1:0]  rd_base_q;
    logic [ADDR_W-1:0]  wr_base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   rd_idx;
    logic [LEN_W-1:0]   wr_idx;
    logic [CNT_W-1:0]   outst;

    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  relu_word;
    logic [2:0]         sign_cnt;

    logic               accept_start;
    logic               active;
    logic               rd_hs;
    logic               push;
    logic               pop;
    logic               last_req;

    assign accept_start = (state == IDLE) && start;
    assign active       = (state == RUN) || (state == DRAIN);
    assign rd_req_valid = (state == RUN) && (rd_idx < len_q) &&
                          (({1'b0, outst} + {1'b0, fifo_cnt}) < (CNT_W+1)'(FIFO_DEPTH));
    assign rd_hs        = rd_req_valid && rd_req_ready;
    assign push         = rd_data_valid && active;
    assign wr_valid     = !fifo_empty;
    assign pop          = wr_valid && wr_ready;
    assign last_req     = ({1'b0, rd_idx} + (LEN_W+1)'(1)) == {1'b0, len_q};

    assign rd_req_addr  = rd_base_q + ADDR_W'(rd_idx);
    assign wr_addr      = wr_base_q + ADDR_W'(wr_idx);

    relu_dp u_relu_dp (
        .en   (relu_en_q),
        .din  (rd_data),
        .dout (relu_word)
    );

    relu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (relu_word),
        .pop       (pop),
        .pop_data  (wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    // Count the negative lanes of the incoming word for the clamp statistic
    always_comb begin
        sign_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            sign_cnt = sign_cnt + 3'(rd_data[l*PIX_W + PIX_W - 1]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (cfg_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (rd_hs && last_req) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (wr_idx == len_q) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Config latch, progress indices, outstanding-read credits and clamp statistic
    always_ff @(posedge clk) begin
        if (rst) begin
            relu_en_q <= 1'b0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            len_q     <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
            outst     <= '0;
            clamp_cnt <= '0;
        end else if (accept_start) begin
            relu_en_q <= cfg_relu_en;
            rd_base_q <= cfg_rd_base;
            wr_base_q <= cfg_wr_base;
            len_q     <= cfg_len;
            rd_idx    <= '0;
            wr_idx    <= '0;
            outst     <= '0;
            clamp_cnt <= '0;
        end else begin
            if (rd_hs) begin
                rd_idx <= rd_idx + LEN_W'(1);
            end
            if (pop) begin
                wr_idx <= wr_idx + LEN_W'(1);
            end
            case ({rd_hs, push})
                2'b10:   outst <= outst + CNT_W'(1);
                2'b01:   outst <= outst - CNT_W'(1);
                default: outst <= outst;
            endcase
            if (push && relu_en_q) begin
                clamp_cnt <= clamp_cnt + (LEN_W+2)'(sign_cnt);
            end
        end
    end

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Self-checking bench for relu_seq_ctrl: memory/writer models plus reference queues.
module tb_relu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cfg_relu_en = 1'b0;
    logic [15:0] cfg_rd_base = '0;
    logic [15:0] cfg_wr_base = '0;
    logic [15:0] cfg_len = '0;
    logic        busy;
    logic        done;
    logic        rd_req_valid;
    logic        rd_req_ready = 1'b0;
    logic [15:0] rd_req_addr;
    logic        rd_data_valid = 1'b0;
    logic [63:0] rd_data = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic [17:0] clamp_cnt;

    relu_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_relu_en   (cfg_relu_en),
        .cfg_rd_base   (cfg_rd_base),
        .cfg_wr_base   (cfg_wr_base),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .clamp_cnt     (clamp_cnt)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    logic [63:0] mem [int];
    logic [15:0] exp_rd_q [$];
    logic [15:0] exp_wa_q [$];
    logic [63:0] exp_wd_q [$];
    logic [15:0] pend_q   [$];
    logic [17:0] exp_clamp;
    int          exp_len;
    int          reads_seen, writes_seen, done_seen, busy_seen, rdv_seen, wrv_seen;
    bit          wr_hold = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_wa;
    logic [63:0] prev_wd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory and write-side model: inputs driven and handshakes observed on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            rd_data_valid = 1'b0;
            rd_req_ready  = 1'b0;
            wr_ready      = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            if (pend_q.size() > 0 && $urandom_range(3) != 0) begin
                logic [15:0] a;
                a = pend_q.pop_front();
                rd_data_valid = 1'b1;
                rd_data       = mem.exists(int'(a)) ? mem[int'(a)] : 64'h0;
            end else begin
                rd_data_valid = 1'b0;
                rd_data       = {$urandom, $urandom};
            end

            rd_req_ready = ($urandom_range(3) != 0);
            if (rd_req_valid) rdv_seen++;
            if (rd_req_valid && rd_req_ready) begin
                reads_seen++;
                if (exp_rd_q.size() > 0) check("rd_addr", rd_req_addr, exp_rd_q.pop_front());
                else                     check("rd_count", reads_seen, exp_len);
                pend_q.push_back(rd_req_addr);
            end

            wr_ready = wr_hold ? 1'b0 : ($urandom_range(3) != 0);
            if (wr_valid) wrv_seen++;
            if (prev_stall) begin
                check("wr_stall_valid", wr_valid, 1);
                check("wr_stall_addr", wr_addr, prev_wa);
                check("wr_stall_data", wr_data, prev_wd);
            end
            prev_stall = wr_valid && !wr_ready;
            prev_wa    = wr_addr;
            prev_wd    = wr_data;
            if (wr_valid && wr_ready) begin
                writes_seen++;
                if (exp_wa_q.size() > 0) begin
                    check("wr_addr", wr_addr, exp_wa_q.pop_front());
                    check("wr_data", wr_data, exp_wd_q.pop_front());
                end else begin
                    check("wr_count", writes_seen, exp_len);
                end
            end
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Build the expected pass from the rules, then pulse start
    task automatic start_pass(input logic [15:0] rb, input logic [15:0] wb, input logic [15:0] len,
                              input logic en, input bit const_mode, input logic [63:0] cw);
        mem.delete();
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        exp_clamp   = '0;
        exp_len     = int'(len);
        reads_seen  = 0;
        writes_seen = 0;
        done_seen   = 0;
        busy_seen   = 0;
        rdv_seen    = 0;
        wrv_seen    = 0;
        for (int i = 0; i < int'(len); i++) begin
            logic [15:0] a;
            logic [63:0] w;
            logic [63:0] r;
            logic [15:0] lane;
            a = 16'(int'(rb) + i);
            w = const_mode ? cw : {$urandom, $urandom};
            mem[int'(a)] = w;
            r = w;
            for (int l = 0; l < 4; l++) begin
                lane = w[16*l +: 16];
                if (en && $signed(lane) < 0) begin
                    r[16*l +: 16] = 16'h0;
                    exp_clamp = exp_clamp + 18'd1;
                end
            end
            exp_rd_q.push_back(a);
            exp_wa_q.push_back(16'(int'(wb) + i));
            exp_wd_q.push_back(r);
        end
        cfg_rd_base = rb;
        cfg_wr_base = wb;
        cfg_len     = len;
        cfg_relu_en = en;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
    endtask

    task automatic finish_pass(input string tag, input int budget);
        int n;
        n = 0;
        while (done_seen == 0 && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_done_seen"}, (done_seen > 0), 1);
        tick(2);
        check({tag, "_reads"}, reads_seen, exp_len);
        check({tag, "_writes"}, writes_seen, exp_len);
        check({tag, "_done_once"}, done_seen, 1);
        check({tag, "_clamp"}, clamp_cnt, exp_clamp);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_req_valid", rd_req_valid, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_clamp", clamp_cnt, 0);
        check("rst_rd_addr", rd_req_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        tick(2);

        // 1: clamp enabled, fixed word
        start_pass(16'h0100, 16'h0200, 16'd3, 1'b1, 1'b1, 64'h8000_7FFF_FFFF_0001);
        finish_pass("t1", 200);
        check("t1_clamp_six", clamp_cnt, 6);

        // 2: pass-through
        start_pass(16'h0100, 16'h0200, 16'd3, 1'b0, 1'b1, 64'h8000_7FFF_FFFF_0001);
        finish_pass("t2", 200);
        check("t2_clamp_zero", clamp_cnt, 0);

        // 3: write back-pressure fills the credit window
        wr_hold = 1'b1;
        start_pass(16'h1000, 16'h2000, 16'd16, 1'b1, 1'b0, 64'h0);
        tick(20);
        check("t3_rd_req_stopped", rd_req_valid, 0);
        check("t3_reads_at_credit", reads_seen, 4);
        check("t3_wr_valid_held", wr_valid, 1);
        wr_hold = 1'b0;
        finish_pass("t3", 1000);

        // 4: zero-length pass
        start_pass(16'h0040, 16'h0050, 16'd0, 1'b1, 1'b0, 64'h0);
        check("t4_done_pulse", done, 1);
        check("t4_busy_in_fin", busy, 0);
        tick(1);
        check("t4_done_drop", done, 0);
        tick(3);
        check("t4_no_rd_valid", rdv_seen, 0);
        check("t4_no_wr_valid", wrv_seen, 0);
        check("t4_no_busy", busy_seen, 0);
        check("t4_done_once", done_seen, 1);

        // 5: address wrap on both ports
        start_pass(16'hFFFE, 16'hFFFF, 16'd4, 1'(($urandom_range(1))), 1'b0, 64'h0);
        finish_pass("t5", 300);

        // 6: start ignored mid-run, then reset mid-run, then a clean pass
        start_pass(16'h0300, 16'h0400, 16'd16, 1'b1, 1'b0, 64'h0);
        tick(3);
        cfg_rd_base = 16'h7000;
        cfg_wr_base = 16'h7100;
        cfg_len     = 16'd2;
        cfg_relu_en = 1'b0;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
        check("t6_busy_after_restart", busy, 1);
        tick(3);
        rst = 1'b1;
        tick(1);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rd_req_valid", rd_req_valid, 0);
        check("t6_rst_wr_valid", wr_valid, 0);
        check("t6_rst_clamp", clamp_cnt, 0);
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        rst = 1'b0;
        tick(2);
        start_pass(16'h0500, 16'h0600, 16'd8, 1'b1, 1'b0, 64'h0);
        finish_pass("t6_after", 500);

        // randomized passes
        for (int p = 0; p < 4; p++) begin
            start_pass(16'($urandom), 16'($urandom), 16'($urandom_range(12, 1)),
                       1'($urandom_range(1)), 1'b0, 64'h0);
            finish_pass("rand", 1000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
